// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch responder.
// Optional feature macro: IFETCH_PREFETCH_EN (two-entry buffer with next-line prefetch).
package ifetch_pkg;

`ifdef IFETCH_PREFETCH_EN
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEMAND   = 2'd1,
    ST_PREFETCH = 2'd2
  } ifetch_state_t;
  localparam int unsigned NUM_ENTRIES = 2;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DEMAND = 2'd1
  } ifetch_state_t;
  localparam int unsigned NUM_ENTRIES = 1;
`endif

  // NOP word; the core raises adelF itself for misaligned fetches.
  localparam logic [31:0] IFETCH_ERR_INSTR = 32'h0000_0000;
  localparam logic [31:0] WORD_ALIGN_MASK  = 32'h0000_0003;
  // Highest word address; prefetching past it would wrap to 0.
  localparam logic [31:0] LAST_WORD_ADDR   = 32'hFFFF_FFFC;

  function automatic logic word_aligned(input logic [31:0] addr);
    return (addr & WORD_ALIGN_MASK) == 32'h0000_0000;
  endfunction

endpackage

// File: rtl/ifetch_buf_entry.sv
// One fetch-buffer entry: valid/tag/data registers, a fill port and a
// combinational tag match against the fetch address.
// Optional feature macro: IFETCH_PREFETCH_EN adds a second probe compare.
module ifetch_buf_entry (
  input  logic        clk,
  input  logic        reset,
  input  logic        fill,
  input  logic [31:0] fill_tag,
  input  logic [31:0] fill_data,
  input  logic [31:0] lookup,
`ifdef IFETCH_PREFETCH_EN
  input  logic [31:0] probe,
  output logic        probe_match,
`endif
  output logic        match,
  output logic [31:0] data
);

  logic        valid;
  logic [31:0] tag;

  // Entry storage: cleared by reset, overwritten whole on a fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      tag   <= 32'h0000_0000;
      data  <= 32'h0000_0000;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_tag;
      data  <= fill_data;
    end
  end

  assign match = valid && (tag == lookup);

`ifdef IFETCH_PREFETCH_EN
  assign probe_match = valid && (tag == probe);
`endif

endmodule

// File: rtl/inst_fetch_responder.sv
// Instruction-side responder: answers the fetch port from a tagged fetch
// buffer and forwards misses to backing memory over a req/ack handshake.
// Optional feature macro: IFETCH_PREFETCH_EN (two entries, next-line prefetch).
module inst_fetch_responder
  import ifetch_pkg::*;
#(
  parameter logic [31:0] ERR_INSTR = IFETCH_ERR_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  output logic        stall_by_iram,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  logic                   aligned;
  logic                   hit;
  logic                   miss;
  logic [31:0]            hit_data;
  logic [NUM_ENTRIES-1:0] e_match;
  logic [NUM_ENTRIES-1:0] e_fill;
  logic [31:0]            e_data [NUM_ENTRIES];
  logic                   fill_any;
  ifetch_state_t          state;
  ifetch_state_t          next_state;
  logic                   req_nxt;
  logic [31:0]            addr_nxt;

`ifdef IFETCH_PREFETCH_EN
  logic                   hit_slot;
  logic                   last_hit;
  logic                   req_slot;
  logic                   slot_nxt;
  logic                   pf_pending;
  logic                   pf_slot;
  logic [31:0]            pf_base;
  logic [31:0]            pf_src_base;
  logic                   pf_src_slot;
  logic [31:0]            pf_target;
  logic                   pf_go;
  logic [NUM_ENTRIES-1:0] e_probe;
`endif

  assign aligned = word_aligned(pc);

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
    ifetch_buf_entry u_entry (
      .clk         (clk),
      .reset       (reset),
      .fill        (e_fill[g]),
      .fill_tag    (mem_addr),
      .fill_data   (mem_rdata),
      .lookup      (pc),
`ifdef IFETCH_PREFETCH_EN
      .probe       (pf_target),
      .probe_match (e_probe[g]),
`endif
      .match       (e_match[g]),
      .data        (e_data[g])
    );
  end

  // Select the data (and, with prefetch, the index) of the matching entry.
  always_comb begin
    hit_data = ERR_INSTR;
`ifdef IFETCH_PREFETCH_EN
    hit_slot = 1'b0;
`endif
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      hit_data = e_match[i] ? e_data[i] : hit_data;
`ifdef IFETCH_PREFETCH_EN
      hit_slot = e_match[i] ? 1'(i) : hit_slot;
`endif
    end
  end

  assign hit           = aligned && (|e_match);
  assign miss          = aligned && !hit;
  assign instr         = hit ? hit_data : ERR_INSTR;
  assign stall_by_iram = miss;

`ifdef IFETCH_PREFETCH_EN
  assign e_fill = {fill_any && req_slot, fill_any && !req_slot};

  // Next-line candidate: the just-filled demand address, else the current hit.
  always_comb begin
    pf_src_base = pf_pending ? pf_base : pc;
    pf_src_slot = pf_pending ? pf_slot : hit_slot;
    pf_target   = pf_src_base + 32'd4;
    pf_go       = (pf_pending || hit) && (pf_src_base != LAST_WORD_ADDR) && !(|e_probe);
  end
`else
  assign e_fill = fill_any;
`endif

  // Next-state and next request decode; demand misses take priority over prefetch.
  always_comb begin
    next_state = state;
    req_nxt    = mem_req;
    addr_nxt   = mem_addr;
    fill_any   = 1'b0;
`ifdef IFETCH_PREFETCH_EN
    slot_nxt   = req_slot;
`endif
    case (state)
      ST_IDLE: begin
        if (miss) begin
          next_state = ST_DEMAND;
          req_nxt    = 1'b1;
          addr_nxt   = pc;
`ifdef IFETCH_PREFETCH_EN
          slot_nxt   = ~last_hit;
`endif
        end
`ifdef IFETCH_PREFETCH_EN
        else if (pf_go) begin
          next_state = ST_PREFETCH;
          req_nxt    = 1'b1;
          addr_nxt   = pf_target;
          slot_nxt   = ~pf_src_slot;
        end
`endif
        else begin
          next_state = ST_IDLE;
        end
      end
      ST_DEMAND: begin
        if (mem_ack) begin
          fill_any   = 1'b1;
          req_nxt    = 1'b0;
          next_state = ST_IDLE;
        end else begin
          next_state = ST_DEMAND;
        end
      end
`ifdef IFETCH_PREFETCH_EN
      ST_PREFETCH: begin
        if (mem_ack) begin
          fill_any   = 1'b1;
          req_nxt    = 1'b0;
          next_state = ST_IDLE;
        end else begin
          next_state = ST_PREFETCH;
        end
      end
`endif
      default: begin
        next_state = ST_IDLE;
        req_nxt    = 1'b0;
      end
    endcase
  end

  // State and registered request outputs; reset drops any outstanding request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      mem_req  <= 1'b0;
      mem_addr <= 32'h0000_0000;
    end else begin
      state    <= next_state;
      mem_req  <= req_nxt;
      mem_addr <= addr_nxt;
    end
  end

`ifdef IFETCH_PREFETCH_EN
  // Replacement and prefetch bookkeeping: fill target, recency, pending next-line.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_hit   <= 1'b1;
      req_slot   <= 1'b0;
      pf_pending <= 1'b0;
      pf_base    <= 32'h0000_0000;
      pf_slot    <= 1'b0;
    end else begin
      req_slot   <= slot_nxt;
      pf_pending <= fill_any && (state == ST_DEMAND);
      if (fill_any && (state == ST_DEMAND)) begin
        pf_base  <= mem_addr;
        pf_slot  <= req_slot;
        last_hit <= req_slot;
      end else if (hit) begin
        last_hit <= hit_slot;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Self-checking bench for inst_fetch_responder with a latency-programmable
// backing-memory model and a scoreboard of expected fetch results.
// Prefetch-specific scenarios run only when IFETCH_PREFETCH_EN is defined.
`timescale 1ns/1ps
module tb_inst_fetch_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        stall_by_iram;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int mem_lat = 0;
  bit mem_auto = 1'b1;
  int wait_cnt = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } sb_item_t;
  sb_item_t sb[$];
  sb_item_t mon_it;

  always #5 clk = ~clk;

  inst_fetch_responder dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .instr         (instr),
    .stall_by_iram (stall_by_iram),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h3C08_BFC0;
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [31:0] a);
    pc = a;
    if (a[1:0] == 2'b00) sb.push_back('{a, mem_word(a)});
  endtask

  // Redirect: the pending fetch is abandoned by the core, so drop its expectation.
  task automatic redirect_pc(input logic [31:0] a);
    if (sb.size() > 0) void'(sb.pop_front());
    set_pc(a);
  endtask

  task automatic wait_req(input logic level);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (mem_req === level) return;
      step();
    end
  endtask

  task automatic wait_nostall();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (stall_by_iram === 1'b0) return;
      step();
    end
  endtask

  task automatic wait_idle();
    int quiet = 0;
    for (int i = 0; i < 40 && quiet < 3; i++) begin
      @(negedge clk);
      if (!mem_req) quiet++;
      else quiet = 0;
    end
  endtask

  // Backing memory: acks mem_lat cycles after the request is first seen.
  always @(posedge clk) begin
    #1;
    if (mem_auto) begin
      mem_ack = 1'b0;
      if (mem_req) begin
        if (wait_cnt >= mem_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Output monitor: misaligned rule every cycle; scoreboard pop on a valid fetch.
  always @(negedge clk) begin
    if (pc[1:0] != 2'b00) begin
      check_val("misaligned_instr", instr, 32'h0000_0000);
      check_val("misaligned_stall", 32'(stall_by_iram), 32'd0);
    end else if (!stall_by_iram && sb.size() > 0) begin
      mon_it = sb.pop_front();
      check_val("sb_addr", pc, mon_it.addr);
      check_val("sb_instr", instr, mon_it.data);
    end
  end

  initial begin
    int n;
    int first_req;
    bit rise;

    reset     = 1'b1;
    pc        = 32'h0000_0000;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0000_0000;
    mem_lat   = 2;
    set_pc(32'hBFC0_0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_req", 32'(mem_req), 32'd0);
    check_val("rst_addr", mem_addr, 32'h0000_0000);
    check_val("rst_stall", 32'(stall_by_iram), 32'd1);
    check_val("rst_instr", instr, 32'h0000_0000);

    // Cold miss with L=2: four stall cycles, request rises in cycle 1.
    step();
    reset = 1'b0;
    n = 0;
    first_req = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req && first_req < 0) first_req = i;
      if (!stall_by_iram) break;
      n++;
      step();
    end
    check_val("cold_stall_cycles", 32'(n), 32'd4);
    check_val("cold_req_cycle", 32'(first_req), 32'd1);
    check_val("cold_instr", instr, 32'h3C08_BFC0);

    // Misaligned fetch: NOP, no stall, no request.
    wait_idle();
    step();
    set_pc(32'hBFC0_0002);
    rise = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (mem_req) rise = 1'b1;
      step();
    end
    check_val("misaligned_no_req", 32'(rise), 32'd0);

    // Re-present the cold address: immediate hit.
    set_pc(32'hBFC0_0000);
    @(negedge clk);
    check_val("rehit_stall", 32'(stall_by_iram), 32'd0);
    check_val("rehit_instr", instr, 32'h3C08_BFC0);
`ifndef IFETCH_PREFETCH_EN
    rise = 1'b0;
    repeat (3) begin
      step();
      @(negedge clk);
      if (mem_req) rise = 1'b1;
    end
    check_val("rehit_no_req", 32'(rise), 32'd0);
`endif

    // Redirect mid-request: 0x100 fill completes, then a fresh 0x380 request.
    wait_idle();
    mem_lat = 3;
    step();
    set_pc(32'h0000_0100);
    step();
    step();
    @(negedge clk);
    check_val("redir_req", 32'(mem_req), 32'd1);
    check_val("redir_addr", mem_addr, 32'h0000_0100);
    step();
    redirect_pc(32'h0000_0380);
    @(negedge clk);
    check_val("redir_addr_hold", mem_addr, 32'h0000_0100);
    check_val("redir_stall", 32'(stall_by_iram), 32'd1);
    step();
    wait_req(1'b0);
    check_val("redir_gap_req", 32'(mem_req), 32'd0);
    check_val("redir_gap_stall", 32'(stall_by_iram), 32'd1);
    step();
    wait_req(1'b1);
    check_val("redir_new_addr", mem_addr, 32'h0000_0380);
    check_val("redir_new_stall", 32'(stall_by_iram), 32'd1);
    step();
    wait_nostall();
    check_val("redir_done", instr, mem_word(32'h0000_0380));

    // Reset during DEMAND, stale ack one cycle later is ignored.
    wait_idle();
    mem_auto = 1'b0;
    step();
    set_pc(32'h0000_0100);
    step();
    @(negedge clk);
    check_val("rmr_req_up", 32'(mem_req), 32'd1);
    step();
    reset = 1'b1;
    step();
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_val("rmr_req_dropped", 32'(mem_req), 32'd0);
    check_val("rmr_stall", 32'(stall_by_iram), 32'd1);
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    check_val("rmr_reissue_req", 32'(mem_req), 32'd1);
    check_val("rmr_reissue_addr", mem_addr, 32'h0000_0100);
    check_val("rmr_still_miss", 32'(stall_by_iram), 32'd1);
    mem_lat  = 0;
    wait_cnt = 0;
    mem_auto = 1'b1;
    step();
    wait_nostall();
    check_val("rmr_fill", instr, mem_word(32'h0000_0100));

    // Spurious ack while idle leaves outputs and the buffer alone.
    wait_idle();
    mem_auto = 1'b0;
    step();
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check_val("spur_instr", instr, mem_word(32'h0000_0100));
    check_val("spur_stall", 32'(stall_by_iram), 32'd0);
    check_val("spur_req", 32'(mem_req), 32'd0);
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    check_val("spur_instr_after", instr, mem_word(32'h0000_0100));
    check_val("spur_req_after", 32'(mem_req), 32'd0);
    mem_auto = 1'b1;

`ifdef IFETCH_PREFETCH_EN
    // Demand fill of 0x200 (L=1) is followed straight away by a 0x204 prefetch.
    step();
    reset   = 1'b1;
    mem_lat = 1;
    set_pc(32'h0000_0200);
    step();
    reset = 1'b0;
    wait_nostall();
    check_val("pf_demand_hit", instr, mem_word(32'h0000_0200));
    step();
    @(negedge clk);
    check_val("pf_req", 32'(mem_req), 32'd1);
    check_val("pf_addr", mem_addr, 32'h0000_0204);
    step();
    set_pc(32'h0000_0204);
    @(negedge clk);
    check_val("pf_ack", 32'(mem_ack), 32'd1);
    step();
    @(negedge clk);
    check_val("pf_hit_after_ack", 32'(stall_by_iram), 32'd0);
    check_val("pf_hit_instr", instr, mem_word(32'h0000_0204));

    // Top word address: no wrapping prefetch.
    wait_idle();
    step();
    set_pc(32'hFFFF_FFFC);
    wait_nostall();
    rise = 1'b0;
    repeat (4) begin
      step();
      @(negedge clk);
      if (mem_req) rise = 1'b1;
    end
    check_val("pf_top_no_req", 32'(rise), 32'd0);
`endif

    step();
    check_val("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
